// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin front-end sharing one combinational adder
// between two requesters, with registered operands and a valid/ready response.
module adder_share_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [WIDTH-1:0] rsp0_sum_o,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp1_sum_o,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    input  logic [WIDTH-1:0] add_sum_i
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             gnt_q;
    logic             ptr_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] res_q;
    logic             sel;
    logic             take;

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, handshakes and next-state selection.
    always_comb begin
        state_d      = state_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        take         = 1'b0;
        // Pointer only breaks ties; a lone requester always wins.
        sel = (req0_valid_i & req1_valid_i) ? ptr_q : req1_valid_i;
        unique case (state_q)
            IDLE: begin
                if (!rst_i && (req0_valid_i || req1_valid_i)) begin
                    take         = 1'b1;
                    req0_ready_o = ~sel;
                    req1_ready_o = sel;
                    state_d      = ADD;
                end
            end
            ADD: begin
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid_o = ~gnt_q;
                rsp1_valid_o = gnt_q;
                if (gnt_q ? rsp1_ready_i : rsp0_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture on accept, sum capture during the single ADD cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q  <= 1'b0;
            ptr_q  <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
            res_q  <= '0;
        end else begin
            if (take) begin
                op_a_q <= sel ? req1_a_i : req0_a_i;
                op_b_q <= sel ? req1_b_i : req0_b_i;
                gnt_q  <= sel;
                ptr_q  <= ~sel;
            end
            if (state_q == ADD) begin
                res_q <= add_sum_i;
            end
        end
    end

    assign add_a_o    = op_a_q;
    assign add_b_o    = op_b_q;
    assign rsp0_sum_o = res_q;
    assign rsp1_sum_o = res_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed checks of arbitration, latency,
// wrap-around, backpressure and mid-operation reset.
module tb_adder_share_arbiter;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [W-1:0] rsp0_sum;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp1_sum;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_sum;

    int nvec = 0;
    int nerr = 0;

    adder_share_arbiter #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_ready_i (rsp0_ready),
        .rsp0_sum_o   (rsp0_sum),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_ready_i (rsp1_ready),
        .rsp1_sum_o   (rsp1_sum),
        .add_a_o      (add_a),
        .add_b_o      (add_b),
        .add_sum_i    (add_sum)
    );

    // Stand-in for the shared combinational adder.
    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on channel ch, response taken immediately.
    task automatic do_op(input logic ch, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        if (ch) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        chk("op_rdy", {63'd0, ch ? req1_ready : req0_ready}, 64'd1);
        chk("op_rdy_other", {63'd0, ch ? req0_ready : req1_ready}, 64'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("op_add_a", add_a, a);
        chk("op_add_b", add_b, b);
        chk("op_rdy_add", {62'd0, req0_ready, req1_ready}, 64'd0);
        tick();
        chk("op_rsp_v", {62'd0, rsp1_valid, rsp0_valid},
            ch ? 64'd2 : 64'd1);
        chk("op_rsp_sum", ch ? rsp1_sum : rsp0_sum, exp);
        tick();
        chk("op_rsp_done", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    endtask

    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];
    logic [W-1:0] held;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        // Reset state, even with a valid request pending.
        chk("rst_rdy", {62'd0, req0_ready, req1_ready}, 64'd0);
        chk("rst_rspv", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        chk("rst_add_a", add_a, 64'd0);
        chk("rst_add_b", add_b, 64'd0);
        chk("rst_sum0", rsp0_sum, 64'd0);
        chk("rst_sum1", rsp1_sum, 64'd0);
        req0_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single op and wrap-around cases.
        do_op(1'b0, 64'd3, 64'd5, 64'd8);
        do_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        do_op(1'b0, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 64'd0);

        // Contention: pointer is 0 again after three alternate grants?
        // Grants so far 0,1,0 -> pointer 1; reset to restart at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req0_valid = 1'b1; req0_a = 64'd10;  req0_b = 64'd20;
        req1_valid = 1'b1; req1_a = 64'd100; req1_b = 64'd200;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("ct_rdy", {62'd0, req1_ready, req0_ready},
                k[0] ? 64'd2 : 64'd1);
            tick();
            chk("ct_add_rdy", {62'd0, req1_ready, req0_ready}, 64'd0);
            tick();
            chk("ct_rspv", {62'd0, rsp1_valid, rsp0_valid},
                k[0] ? 64'd2 : 64'd1);
            chk("ct_sum", k[0] ? rsp1_sum : rsp0_sum,
                k[0] ? 64'd300 : 64'd30);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on channel 0 while requester 1 waits.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd40; req0_b = 64'd2;
        req1_valid = 1'b1; req1_a = 64'd5;  req1_b = 64'd6;
        #1;
        chk("bp_rdy0", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        held = rsp0_sum;
        chk("bp_sum_first", held, 64'd42);
        for (int k = 0; k < 5; k++) begin
            chk("bp_v", {62'd0, rsp1_valid, rsp0_valid}, 64'd1);
            chk("bp_sum", rsp0_sum, 64'd42);
            chk("bp_rdy1", {63'd0, req1_ready}, 64'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        chk("bp_rdy1_same", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("bp_rdy1_next", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_rsp1_v", {62'd0, rsp1_valid, rsp0_valid}, 64'd2);
        chk("bp_rsp1_sum", rsp1_sum, 64'd11);
        tick();

        // Reset during ADD.
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_add_a", add_a, 64'd0);
        chk("mr_add_b", add_b, 64'd0);
        chk("mr_rspv", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        chk("mr_sum", rsp0_sum, 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr_stale", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        end
        do_op(1'b1, 64'd7, 64'd9, 64'd16);
        // Pointer back at 0 after reset: a tie now goes to requester 0?
        // Grant 1 just happened, so pointer is 0; verify tie-break.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_tie", {62'd0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;

        // Sweep of 59^i + 73^j, alternating requesters.
        pa[0] = 64'd1; pa[1] = 64'd59; pa[2] = 64'd3481; pa[3] = 64'd205379;
        pb[0] = 64'd1; pb[1] = 64'd73; pb[2] = 64'd5329; pb[3] = 64'd389017;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                do_op(j[0] ^ i[0], pa[i], pb[j], pa[i] + pb[j]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
